sort_sequencer: RTL and testbench

Control block for the bitonic sort datapath. Collects `DEPTH` words of `WIDTH` bits from the UART receiver byte stream, with bytes arriving LSB-first. Loads the words into the sorter and starts it, captures the sorted result, then streams it back to the UART transmitter, also LSB-first. It sits between the UART RX/TX cores and the sorter inside the top-level UART sort design.

---
 rtl/sort_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sort_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// Sequencer between the UART byte stream and the bitonic sorter: gathers DEPTH
// words LSB-first, starts the sorter, then streams the sorted words back out.
module sort_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int NUM_SEQ    = 10,
  parameter int RX_TIMEOUT = 200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [WIDTH*DEPTH-1:0]     sort_data,
  output logic                       sort_start,
  input  logic                       sort_done,
  input  logic [WIDTH*DEPTH-1:0]     sort_result,
  output logic [$clog2(NUM_SEQ)-1:0] seq_count,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int BYTES  = WIDTH / 8;
  localparam int TOTAL  = DEPTH * BYTES;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WIDX_W = $clog2(DEPTH);
  localparam int TXI_W  = $clog2(TOTAL + 1);
  localparam int IDLE_W = $clog2(RX_TIMEOUT);
  localparam int SEQ_W  = $clog2(NUM_SEQ);

  typedef enum logic [2:0] {
    S_RX, S_START, S_WAIT, S_TX, S_TXW, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BIDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [WIDX_W-1:0]      word_idx_q, word_idx_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [WIDTH*DEPTH-1:0] sort_data_q, sort_data_d;
  logic [WIDTH*DEPTH-1:0] tx_buf_q, tx_buf_d;
  logic [TXI_W-1:0]       tx_idx_q, tx_idx_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   guard_q, guard_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RX;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      idle_q      <= '0;
      sort_data_q <= '0;
      tx_buf_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      guard_q     <= 1'b0;
      seq_q       <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      idle_q      <= idle_d;
      sort_data_q <= sort_data_d;
      tx_buf_q    <= tx_buf_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      guard_q     <= guard_d;
      seq_q       <= seq_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    int rx_pos;
    int tx_pos;
    rx_pos      = (int'(word_idx_q) * BYTES + int'(byte_idx_q)) * 8;
    tx_pos      = (int'(tx_idx_q) + 1) * 8;
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    idle_d      = idle_q;
    sort_data_d = sort_data_q;
    tx_buf_d    = tx_buf_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    guard_d     = guard_q;
    seq_d       = seq_q;
    timeout_d   = 1'b0;
    tx_start    = 1'b0;
    sort_start  = 1'b0;
    // A byte arriving while the sorter or transmitter owns the buffers is lost.
    overrun_d   = overrun_q | (rx_valid && (state_q != S_RX));

    case (state_q)
      S_RX: begin
        if (rx_valid) begin
          sort_data_d[rx_pos +: 8] = rx_data;
          idle_d = '0;
          if (byte_idx_q == BIDX_W'(BYTES - 1)) begin
            byte_idx_d = '0;
            if (word_idx_q == WIDX_W'(DEPTH - 1)) begin
              word_idx_d = '0;
              state_d    = S_START;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if ((byte_idx_q != '0) || (word_idx_q != '0)) begin
          // Idle timer only runs once a sequence has started arriving.
          if (idle_q == IDLE_W'(RX_TIMEOUT - 1)) begin
            timeout_d  = 1'b1;
            byte_idx_d = '0;
            word_idx_d = '0;
            idle_d     = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      S_START: begin
        sort_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (sort_done) begin
          tx_buf_d  = sort_result;
          tx_idx_d  = '0;
          tx_data_d = sort_result[7:0];
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          guard_d  = 1'b1;
          state_d  = S_TXW;
        end
      end
      S_TXW: begin
        // The transmitter raises busy one cycle late, so skip the first sample.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!tx_busy) begin
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == TXI_W'(TOTAL - 1)) begin
            state_d = S_DONE;
          end else begin
            tx_data_d = tx_buf_q[tx_pos +: 8];
            state_d   = S_TX;
          end
        end
      end
      S_DONE: begin
        seq_d      = (seq_q == SEQ_W'(NUM_SEQ - 1)) ? '0 : seq_q + 1'b1;
        byte_idx_d = '0;
        word_idx_d = '0;
        idle_d     = '0;
        tx_idx_d   = '0;
        state_d    = S_RX;
      end
      default: state_d = S_RX;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign sort_data   = sort_data_q;
  assign seq_count   = seq_q;
  assign busy        = (state_q != S_RX);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer with a 20-cycle sorter model and a simple
// UART transmitter model; expected sorted words are hand-computed constants.
module tb_sort_sequencer;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int NUM_SEQ = 10;
  localparam int RX_TO   = 300;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic [WIDTH*DEPTH-1:0] sort_data;
  logic                   sort_start;
  logic                   sort_done = 1'b0;
  logic [WIDTH*DEPTH-1:0] sort_result = '0;
  logic [3:0]             seq_count;
  logic                   busy;
  logic                   overrun;
  logic                   timeout_err;

  always #5 clk = ~clk;

  sort_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SEQ(NUM_SEQ), .RX_TIMEOUT(RX_TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .sort_data(sort_data), .sort_start(sort_start), .sort_done(sort_done),
    .sort_result(sort_result), .seq_count(seq_count), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sorter model: fixed 20-cycle latency
  function automatic logic [255:0] sort_words(input logic [255:0] d);
    logic [31:0] w[8];
    logic [31:0] t;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) w[i] = d[i*32 +: 32];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (w[j] > w[j+1]) begin
          t = w[j]; w[j] = w[j+1]; w[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  logic [255:0] sorted_q = '0;
  int lat = 0;
  always @(posedge clk) begin
    sort_done <= 1'b0;
    if (sort_start) begin
      sorted_q <= sort_words(sort_data);
      lat      <= 20;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        sort_done   <= 1'b1;
        sort_result <= sorted_q;
      end
    end
  end

  // Transmitter model: busy for 4 cycles after each start, plus forced hold
  int busy_cnt = 0;
  logic hold = 1'b0;
  logic [7:0] txq[$];
  int hold_viol = 0;
  assign tx_busy = (busy_cnt != 0) || hold;
  always @(posedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      busy_cnt <= 4;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (tx_start && hold) hold_viol++;
  end

  int cyc = 0, last_rx_cyc = 0, start_cyc = 0, n_start = 0, n_to = 0;
  always @(posedge clk) begin
    cyc++;
    if (rx_valid) last_rx_cyc = cyc;
    if (sort_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (timeout_err) n_to++;
  end

  logic [31:0] vin[8];
  logic [31:0] vexp[8];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_words();
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) send_byte(vin[w][b*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 20000 && txq.size() < n; i++) @(negedge clk);
    chk(tag, 64'(txq.size() >= n), 64'd1);
  endtask

  task automatic set_a();
    vin  = '{32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd21, 32'd1};
    vexp = '{32'd1, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd21};
  endtask

  task automatic set_b();
    vin  = '{32'd10, 32'd20, 32'd21, 32'd42, 32'd1, 32'd2, 32'd4, 32'd5};
    vexp = '{32'd1, 32'd2, 32'd4, 32'd5, 32'd10, 32'd20, 32'd21, 32'd42};
  endtask

  task automatic run_seq(input string tag, input bit inject, input bit do_hold);
    int s0;
    int hv0;
    int q0;
    logic [31:0] got;
    s0 = n_start;
    txq.delete();
    send_words();
    if (inject) begin
      for (int i = 0; i < 100 && n_start == s0; i++) @(negedge clk);
      send_byte(8'hAA);
      chk({tag, "_overrun"}, 64'(overrun), 64'd1);
    end
    if (do_hold) begin
      wait_tx(10, {tag, "_pre_hold"});
      hold = 1'b1;
      hv0  = hold_viol;
      q0   = txq.size();
      repeat (1000) @(negedge clk);
      chk({tag, "_hold_starts"}, 64'(hold_viol - hv0), 64'd0);
      chk({tag, "_hold_bytes"}, 64'(txq.size()), 64'(q0));
      hold = 1'b0;
    end
    wait_tx(32, {tag, "_tx_timeout"});
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    chk({tag, "_nbytes"}, 64'(txq.size()), 64'd32);
    chk({tag, "_nstart"}, 64'(n_start - s0), 64'd1);
    if (txq.size() >= 32)
      for (int w = 0; w < 8; w++) begin
        got = {txq[4*w+3], txq[4*w+2], txq[4*w+1], txq[4*w]};
        chk($sformatf("%s_w%0d", tag, w), 64'(got), 64'(vexp[w]));
      end
  endtask

  initial begin
    int s0;
    int t0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_seq_count", 64'(seq_count), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_sort_start", 64'(sort_start), 64'd0);
    chk("rst_sort_data", 64'(|sort_data), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_a();
    run_seq("seq1", 1'b0, 1'b0);
    chk("seq1_sd_w0", 64'(sort_data[31:0]), 64'd1);
    chk("seq1_sd_w6", 64'(sort_data[6*32 +: 32]), 64'd21);
    chk("seq1_start_cyc", 64'(start_cyc), 64'(last_rx_cyc + 1));
    if (txq.size() >= 32) begin
      chk("seq1_b0", 64'(txq[0]), 64'h01);
      chk("seq1_b1", 64'(txq[1]), 64'h00);
      chk("seq1_b4", 64'(txq[4]), 64'h01);
      chk("seq1_b8", 64'(txq[8]), 64'h02);
      chk("seq1_b28", 64'(txq[28]), 64'h15);
    end
    chk("seq1_count", 64'(seq_count), 64'd1);

    set_b();
    run_seq("seq2", 1'b1, 1'b0);
    chk("seq2_count", 64'(seq_count), 64'd2);
    chk("seq2_overrun_sticky", 64'(overrun), 64'd1);

    set_a();
    run_seq("seq3", 1'b0, 1'b1);
    chk("seq3_count", 64'(seq_count), 64'd3);

    for (int s = 4; s <= 10; s++) begin
      if (s % 2 == 0) set_b(); else set_a();
      run_seq($sformatf("seq%0d", s), 1'b0, 1'b0);
    end
    chk("seq_wrap", 64'(seq_count), 64'd0);

    s0 = n_start;
    t0 = n_to;
    for (int i = 0; i < 5; i++) send_byte(8'h33);
    repeat (RX_TO + 20) @(negedge clk);
    chk("to_pulses", 64'(n_to - t0), 64'd1);
    chk("to_no_start", 64'(n_start - s0), 64'd0);
    set_b();
    run_seq("after_to", 1'b0, 1'b0);
    chk("after_to_count", 64'(seq_count), 64'd1);

    set_a();
    txq.delete();
    send_words();
    wait_tx(10, "mid_rst_pre");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_start", 64'(tx_start), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_seq_count", 64'(seq_count), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    set_b();
    run_seq("post_rst", 1'b0, 1'b0);
    chk("post_rst_count", 64'(seq_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
